// File: rtl/kalman_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed Q16.16 multiplier among NUM_REQ requesters.
// One operation in flight; done pulses one-hot with a saturated product.
module kalman_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int MUL_LAT = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_in,
    input  logic [NUM_REQ*DATA_W-1:0]   a_in,
    input  logic [NUM_REQ*DATA_W-1:0]   b_in,
    output logic [NUM_REQ-1:0]          gnt_out,
    output logic [NUM_REQ-1:0]          done_out,
    output logic [DATA_W-1:0]           result_out,
    output logic                        sat_out,
    output logic                        busy_out
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic [IDX_W-1:0]           gidx_q, gidx_d;
    logic [NUM_REQ-1:0]         gnt_q, gnt_d;
    logic [NUM_REQ-1:0]         mask_q, mask_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]          result_q, result_d;
    logic                       sat_q, sat_d;
    logic signed [PROD_W-1:0]   pipe_q [MUL_LAT];

    logic [NUM_REQ-1:0]         elig;
    logic                       pick_valid;
    logic [IDX_W-1:0]           pick_idx;
    int                         scan_idx;

    logic signed [DATA_W-1:0]   a_sel, b_sel;
    logic signed [PROD_W-1:0]   prod_c;
    logic signed [PROD_W-1:0]   shifted;
    logic [PROD_W-DATA_W:0]     top_bits;
    logic                       ovf;
    logic [DATA_W-1:0]          sat_res;

    // The requester served last is hidden for the single IDLE cycle after its done.
    always_comb begin
        elig       = req_in & ~mask_q;
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (!pick_valid && elig[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(scan_idx);
            end
        end
    end

    assign a_sel  = a_in[gidx_q*DATA_W +: DATA_W];
    assign b_sel  = b_in[gidx_q*DATA_W +: DATA_W];
    assign prod_c = PROD_W'(a_sel) * PROD_W'(b_sel);

    // Floor rounding comes from the arithmetic shift; overflow when the discarded top bits are not a sign extension.
    assign shifted  = pipe_q[MUL_LAT-1] >>> FRAC_W;
    assign top_bits = shifted[PROD_W-1:DATA_W-1];
    assign ovf      = !((&top_bits) || !(|top_bits));
    assign sat_res  = !ovf ? shifted[DATA_W-1:0]
                    : (shifted[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}});

    // NOTE: every variable gets its default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        gnt_d    = gnt_q;
        mask_d   = '0;
        cnt_d    = cnt_q;
        result_d = result_q;
        sat_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gidx_d  = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(MUL_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    result_d = sat_res;
                    sat_d    = ovf;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                mask_d  = gnt_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            gnt_q    <= gnt_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    // NOTE: the pipeline is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
        end else begin
            if (state_q == S_ISSUE) pipe_q[0] <= prod_c;
            for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign gnt_out    = gnt_q;
    assign done_out   = (state_q == S_DONE) ? gnt_q : '0;
    assign result_out = result_q;
    assign sat_out    = sat_q;
    assign busy_out   = (state_q != S_IDLE);

endmodule

// File: tb/tb_kalman_mult_arbiter.sv
// Directed bench for kalman_mult_arbiter: products, saturation, round-robin order,
// post-done masking and asynchronous reset in the middle of an operation.
module tb_kalman_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk_in = 1'b0;
    logic                      rst_n  = 1'b0;
    logic [NUM_REQ-1:0]        req_in = '0;
    logic [NUM_REQ*DATA_W-1:0] a_in   = '0;
    logic [NUM_REQ*DATA_W-1:0] b_in   = '0;
    logic [NUM_REQ-1:0]        gnt_out;
    logic [NUM_REQ-1:0]        done_out;
    logic [DATA_W-1:0]         result_out;
    logic                      sat_out;
    logic                      busy_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_gnt = 0;

    kalman_mult_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .FRAC_W(16), .MUL_LAT(3)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt_out   (gnt_out),
        .done_out  (done_out),
        .result_out(result_out),
        .sat_out   (sat_out),
        .busy_out  (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic set_ops(input int k, input logic [31:0] a, input logic [31:0] b);
        a_in[k*DATA_W +: DATA_W] = a;
        b_in[k*DATA_W +: DATA_W] = b;
    endtask

    // Full single-requester transaction with exact cycle checks; req drops right after grant.
    task automatic run_op(input string tag, input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_sat);
        req_in[k] = 1'b1;
        set_ops(k, a, b);
        tick();
        check({tag, "_gnt"}, 32'(gnt_out), 32'(1 << k));
        check({tag, "_busy"}, 32'(busy_out), 32'd1);
        req_in[k] = 1'b0;
        tick();
        set_ops(k, 32'hDEADBEEF, 32'h12345678);
        tick();
        tick();
        check({tag, "_early_done"}, 32'(done_out), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done_out), 32'(1 << k));
        check({tag, "_res"}, result_out, exp_res);
        check({tag, "_sat"}, 32'(sat_out), 32'(exp_sat));
        check({tag, "_gnt_at_done"}, 32'(gnt_out), 32'(1 << k));
        tick();
        check({tag, "_done_clr"}, 32'(done_out), 32'd0);
        check({tag, "_sat_clr"}, 32'(sat_out), 32'd0);
        check({tag, "_gnt_clr"}, 32'(gnt_out), 32'd0);
        check({tag, "_idle"}, 32'(busy_out), 32'd0);
        check({tag, "_res_hold"}, result_out, exp_res);
    endtask

    initial begin
        #1;
        check("rst_gnt", 32'(gnt_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_res", result_out, 32'd0);
        check("rst_sat", 32'(sat_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic products and saturation.
        run_op("t1_pos", 0, 32'h00018000, 32'h00020000, 32'h00030000, 1'b0);
        run_op("t2_neg", 1, 32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0);
        run_op("t3_floor", 2, 32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFF, 1'b0);
        run_op("t3_satp", 3, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFFFFFF, 1'b1);

        // Round-robin with all requesters held, each dropping after its own done.
        for (int k = 0; k < NUM_REQ; k++) set_ops(k, 32'((k + 1) << 16), 32'h00020000);
        req_in = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            tick();
            check("t4_rr_gnt", 32'(gnt_out), 32'(1 << k));
            if (k > 0) check("t4_rr_spacing", 32'(cyc - last_gnt), 32'd6);
            last_gnt = cyc;
            tick();
            tick();
            tick();
            tick();
            check("t4_rr_done", 32'(done_out), 32'(1 << k));
            check("t4_rr_res", result_out, 32'((2 * (k + 1)) << 16));
            req_in[k] = 1'b0;
            tick();
        end
        req_in = 4'b1001;
        tick();
        check("t4_wrap_gnt", 32'(gnt_out), 32'b0001);
        req_in = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        check("t4_wrap_done", 32'(done_out), 32'b0001);
        tick();

        run_op("t3_satn", 3, 32'h7FFF0000, 32'h80000000, 32'h80000000, 1'b1);

        // Held request is masked for one IDLE cycle, then pointer order decides.
        set_ops(2, 32'h00030000, 32'h00010000);
        set_ops(3, 32'h00008000, 32'h00008000);
        req_in = 4'b0100;
        tick();
        check("t5_gnt2", 32'(gnt_out), 32'b0100);
        tick();
        tick();
        tick();
        tick();
        check("t5_done2", 32'(done_out), 32'b0100);
        tick();
        tick();
        check("t5_masked", 32'(gnt_out), 32'd0);
        check("t5_masked_busy", 32'(busy_out), 32'd0);
        tick();
        check("t5_regnt2", 32'(gnt_out), 32'b0100);
        tick();
        tick();
        tick();
        tick();
        check("t5_redone2", 32'(done_out), 32'b0100);
        check("t5_res2", result_out, 32'h00030000);
        tick();
        tick();
        check("t5_masked2", 32'(gnt_out), 32'd0);
        req_in = 4'b1100;
        tick();
        check("t5_ptr3_first", 32'(gnt_out), 32'b1000);
        req_in[3] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t5_done3", 32'(done_out), 32'b1000);
        check("t5_res3", result_out, 32'h00004000);
        tick();
        tick();
        check("t5_then2", 32'(gnt_out), 32'b0100);
        req_in[2] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t5_done2_last", 32'(done_out), 32'b0100);
        tick();

        // Leaves pointer at 2 so the reset test can tell pointer 0 from a stale pointer.
        run_op("t6_pre", 1, 32'h00020000, 32'h00020000, 32'h00040000, 1'b0);

        set_ops(0, 32'h00010000, 32'h00010000);
        req_in = 4'b0001;
        tick();
        check("t6_gnt0", 32'(gnt_out), 32'b0001);
        req_in = 4'b0000;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt_out), 32'd0);
        check("t6_rst_done", 32'(done_out), 32'd0);
        check("t6_rst_busy", 32'(busy_out), 32'd0);
        check("t6_rst_res", result_out, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_done", 32'(done_out), 32'd0);
        end
        req_in = 4'b0110;
        tick();
        check("t6_ptr_reset", 32'(gnt_out), 32'b0010);
        req_in = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        check("t6_done", 32'(done_out), 32'b0010);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
